// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU-op encodings, funct codes and
// the ID/EX control bundle layout.
package mips_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Field order, MSB first, is the on-wire order of the 9-bit ctrl bundle.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // A bubble carries no side effects: no register write, no memory access,
    // no branch, and a plain add on the ALU.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_OP_ADD;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_ctrl_reg.sv
// ID/EX control-bundle and valid register with reset > flush > stall > load
// priority; also reports whether a bubble is being loaded on this edge.
module id_ex_ctrl_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  logic  id_valid,
    input  ctrl_t id_ctrl,
    output ctrl_t ex_ctrl,
    output logic  ex_valid,
    output logic  load_bubble
);

    // An unstalled slot without a real instruction is treated exactly like a flush.
    always_comb begin
        load_bubble = flush | (~stall & ~id_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl  <= '0;
            ex_valid <= 1'b0;
        end else if (load_bubble) begin
            ex_ctrl  <= bubble_ctrl();
            ex_valid <= 1'b0;
        end else if (!stall) begin
            ex_ctrl  <= id_ctrl;
            ex_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: control bundle (sub-module), operands, immediate,
// PC+4 and register numbers. Optional bubble counter under IDEX_BUBBLE_CNT_EN.
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [1:0]            id_alu_op,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rd_data1,
    input  logic [DATA_W-1:0]     id_rd_data2,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rd_data1,
    output logic [DATA_W-1:0]     ex_rd_data2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [5:0]            ex_funct,
    output logic [31:0]           bubble_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  load_bubble;

    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.branch     = id_branch;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.reg_dst    = id_reg_dst;
        id_ctrl.alu_op     = id_alu_op;
    end

    id_ex_ctrl_reg u_ctrl_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .ex_ctrl     (ex_ctrl),
        .ex_valid    (ex_valid),
        .load_bubble (load_bubble)
    );

    always_comb begin
        ex_reg_write  = ex_ctrl.reg_write;
        ex_mem_to_reg = ex_ctrl.mem_to_reg;
        ex_mem_read   = ex_ctrl.mem_read;
        ex_mem_write  = ex_ctrl.mem_write;
        ex_branch     = ex_ctrl.branch;
        ex_alu_src    = ex_ctrl.alu_src;
        ex_reg_dst    = ex_ctrl.reg_dst;
        ex_alu_op     = ex_ctrl.alu_op;
    end

    // Datapath fields follow the same clear/enable decision as the ctrl bundle.
    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ex_pc_plus4 <= '0;
            ex_rd_data1 <= '0;
            ex_rd_data2 <= '0;
            ex_imm_ext  <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else if (!stall) begin
            ex_pc_plus4 <= id_pc_plus4;
            ex_rd_data1 <= id_rd_data1;
            ex_rd_data2 <= id_rd_data2;
            ex_imm_ext  <= id_imm_ext;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
        end
    end

    // Funct is a view of the registered immediate, so it adds no latency.
    always_comb begin
        ex_funct = ex_imm_ext[5:0];
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else if (load_bubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    always_comb begin
        bubble_cnt = bubble_cnt_q;
    end
`else
    always_comb begin
        bubble_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed scenarios then random traffic
// against a per-edge behavioural model of the register contents.
module tb_id_ex_pipe_reg;

`ifdef IDEX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] cnt;
    } out_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic        id_branch, id_alu_src, id_reg_dst;
    logic [1:0]  id_alu_op;
    logic [31:0] id_pc_plus4, id_rd_data1, id_rd_data2, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [31:0] bubble_cnt;

    out_t        exp_q[$];
    out_t        model;
    logic [31:0] model_cnt;
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
        .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4),
        .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2), .ex_imm_ext(ex_imm_ext),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .bubble_cnt(bubble_cnt)
    );

    // Monitor: one registered snapshot per edge, compared against the queue head.
    always @(posedge clk) begin
        out_t act;
        out_t e;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                   ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc_plus4,
                   ex_rd_data1, ex_rd_data2, ex_imm_ext, ex_rs, ex_rt, ex_rd,
                   ex_funct, bubble_cnt};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ex_outputs cycle=%0d actual=%h expected=%h", cycle, act, e);
            end
        end
    end

    // Reference: what the EX side must hold after this edge, given the inputs now applied.
    task automatic apply();
        out_t e;
        if (reset) begin
            model     = '0;
            model_cnt = 32'd0;
        end else if (flush || (!stall && !id_valid)) begin
            model     = '0;
            model_cnt = model_cnt + 32'd1;
        end else if (!stall) begin
            model.valid      = 1'b1;
            model.reg_write  = id_reg_write;
            model.mem_to_reg = id_mem_to_reg;
            model.mem_read   = id_mem_read;
            model.mem_write  = id_mem_write;
            model.branch     = id_branch;
            model.alu_src    = id_alu_src;
            model.reg_dst    = id_reg_dst;
            model.alu_op     = id_alu_op;
            model.pc         = id_pc_plus4;
            model.d1         = id_rd_data1;
            model.d2         = id_rd_data2;
            model.imm        = id_imm_ext;
            model.rs         = id_rs;
            model.rt         = id_rt;
            model.rd         = id_rd;
            model.funct      = id_imm_ext % 64;
        end
        e     = model;
        e.cnt = CNT_EN ? model_cnt : 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_id();
        id_reg_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_branch     = 1'($urandom);
        id_alu_src    = 1'($urandom);
        id_reg_dst    = 1'($urandom);
        id_alu_op     = 2'($urandom_range(0, 2));
        id_pc_plus4   = $urandom;
        id_rd_data1   = $urandom;
        id_rd_data2   = $urandom;
        id_imm_ext    = $urandom;
        id_rs         = 5'($urandom);
        id_rt         = 5'($urandom);
        id_rd         = 5'($urandom);
    endtask

    task automatic clear_id();
        {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
         id_branch, id_alu_src, id_reg_dst} = '0;
        id_alu_op   = 2'b00;
        id_pc_plus4 = '0;
        id_rd_data1 = '0;
        id_rd_data2 = '0;
        id_imm_ext  = '0;
        id_rs       = '0;
        id_rt       = '0;
        id_rd       = '0;
    endtask

    initial begin
        int wait_cycles;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        model = '0;
        model_cnt = 32'd0;
        rand_id();
        @(negedge clk);

        // Reset held two cycles with live decode inputs.
        id_alu_op = 2'b10;
        apply();
        rand_id();
        stall = 1'b1;
        apply();
        reset = 1'b0; stall = 1'b0;

        // R-type add.
        clear_id();
        id_valid = 1'b1; id_reg_write = 1'b1; id_reg_dst = 1'b1; id_alu_op = 2'b10;
        id_imm_ext = 32'h0000_0020; id_rd_data1 = 32'd5; id_rd_data2 = 32'd7;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_pc_plus4 = 32'h0000_0104;
        apply();

        // lw, then three stalled cycles with changing decode inputs.
        clear_id();
        id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_reg_write = 1'b1; id_alu_src = 1'b1;
        id_rt = 5'd8; id_rs = 5'd29; id_imm_ext = 32'h0000_0010; id_rd_data1 = 32'h1000;
        apply();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            apply();
        end

        // Stall and flush on the same edge: flush wins.
        rand_id();
        flush = 1'b1;
        apply();
        stall = 1'b0; flush = 1'b0;

        // Empty decode slot, then a store.
        rand_id();
        id_valid = 1'b0;
        apply();
        clear_id();
        id_valid = 1'b1; id_mem_write = 1'b1; id_alu_src = 1'b1; id_alu_op = 2'b00;
        id_rs = 5'd4; id_rt = 5'd9; id_imm_ext = 32'hFFFF_FFFC; id_rd_data2 = 32'hDEAD_BEEF;
        apply();

        // Random traffic, including occasional mid-stall resets.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            reset    = ($urandom_range(0, 99) < 3);
            stall    = ($urandom_range(0, 99) < 30);
            flush    = ($urandom_range(0, 99) < 15);
            id_valid = ($urandom_range(0, 99) < 75);
            apply();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
